sel_scanner: RTL
================

SEL_SCANNER -- requirements
Module: sel_scanner

Interface
REQ-001 Parameter CHANNELS, default 8, number of mux channels to scan (2..256).
REQ-002 Parameter SEL_W, default 3, select width; SHALL satisfy 2**SEL_W >= CHANNELS.
REQ-003 Parameter DWELL_CYCLES, default 50_000_000, clk cycles per channel in auto mode (>=2).
REQ-004 Parameter DEBOUNCE_CYCLES, default 500_000, stable cycles required to accept a button level (>=1).
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 mode  input  1  0 = manual stepping, 1 = auto scan; level from a switch.
REQ-008 hold  input  1  1 = freeze auto scan (pause); ignored in manual.
REQ-009 step_btn  input  1  raw asynchronous push button, active-high.
REQ-010 sel  output  SEL_W  registered select driven to the downstream mux sel port.
REQ-011 wrap  output  1  registered one-cycle pulse when sel wraps.
REQ-012 state  output  2  registered FSM state for LED display: 00 MANUAL, 01 AUTO, 10 PAUSE.

Function
REQ-013 mode, hold SHALL pass a 2-flop synchronizer; step_btn SHALL pass a 2-flop synchronizer then the debouncer.
REQ-014 Debouncer SHALL accept a new level only after DEBOUNCE_CYCLES consecutive equal synchronized samples; accepted 0->1 transition yields a one-cycle step pulse.
REQ-015 Latency: step pulse to sel update SHALL be exactly 1 cycle.
REQ-016 Advance rule: sel <= (sel == CHANNELS-1) ? 0 : sel+1; sel SHALL never exceed CHANNELS-1.
REQ-017 wrap SHALL assert in the cycle sel first shows the wrapped value, and only then.
REQ-018 MANUAL: each step pulse advances sel once; no timed advance.
REQ-019 AUTO: dwell counter counts 0..DWELL_CYCLES-1; at terminal count sel advances and counter returns to 0.
REQ-020 AUTO: step pulse advances sel immediately and clears the dwell counter; coincident step pulse and terminal count SHALL produce one advance only.
REQ-021 PAUSE: sel and dwell counter held; step pulse advances sel once, counter stays held.
REQ-022 Transitions: MANUAL->AUTO when mode=1; AUTO->PAUSE when hold=1; PAUSE->AUTO when hold=0; AUTO or PAUSE->MANUAL when mode=0 (mode=0 takes priority over hold).
REQ-023 Entering AUTO from MANUAL SHALL clear the dwell counter; PAUSE->AUTO SHALL resume from the held count.
REQ-024 Mode change never alters sel by itself.

Reset
REQ-025 rst_n low SHALL immediately force sel=0, wrap=0, state=MANUAL, dwell counter=0, debouncer accepted level=0 and its counter=0, synchronizers=0.
REQ-026 Reset assertion mid-dwell or mid-debounce SHALL discard all progress; a button held through reset release produces no step pulse until it is released and pressed again.

Configuration
REQ-027 Macro SEL_SCANNER_DIR_EN: when defined, an extra input dir (1 bit, synchronized, 0=up, 1=down) SHALL exist; down advance is sel <= (sel==0) ? CHANNELS-1 : sel-1 and wrap pulses on 0->CHANNELS-1.
REQ-028 Without SEL_SCANNER_DIR_EN: no dir port; up-count only, per REQ-016.

Structure
REQ-029 Shared package holds the state encoding constants (ST_MANUAL, ST_AUTO, ST_PAUSE) and the clog2 width helper used for counter sizing.
REQ-030 Debouncer SHALL be a separate sub-module named btn_debounce (sync + debounce + rising-edge pulse), reusable for other board buttons.
REQ-031 Dwell and debounce counters SHALL be sized from their parameters, not fixed width.

Verification (CHANNELS=8, SEL_W=3, DWELL_CYCLES=4, DEBOUNCE_CYCLES=3 unless stated)
REQ-032 Reset then mode=0, three clean presses -> sel 0->1->2->3, wrap never asserted, state=00.
REQ-033 Button bouncing 1-2 cycles high before stable high -> exactly one advance; stable press held 20 cycles -> one advance.
REQ-034 mode=1 from sel=6 -> sel advances every 4 cycles 6->7->0->1; wrap high exactly on the 7->0 cycle; state=01.
REQ-035 AUTO, hold=1 for 10 cycles -> state=10, sel frozen; hold=0 -> resumes with remaining dwell; press during PAUSE -> single advance.
REQ-036 CHANNELS=5, SEL_W=3 auto -> sel sequence 0,1,2,3,4,0; values 5..7 never appear; with SEL_SCANNER_DIR_EN and dir=1 -> 0,4,3,2,1,0 with wrap on 0->4.
REQ-037 rst_n pulsed low mid-dwell at sel=5 with button held -> sel=0 asynchronously, state=00, no advance after release until re-press.

Source files
------------

// File: rtl/sel_scanner_pkg.sv
// ---------------------------------------------------------------------------
// sel_scanner_pkg
// Shared definitions for the mux select scanner and its button debouncer.
//
// Contents:
//   ST_MANUAL / ST_AUTO / ST_PAUSE  2-bit FSM state encodings. These values
//                                   also drive the board LEDs directly.
//   clog2_w(value)                  number of bits needed to hold 0..value-1,
//                                   never less than 1. Used to size counters
//                                   from their cycle-count parameters.
// ---------------------------------------------------------------------------
package sel_scanner_pkg;

    localparam logic [1:0] ST_MANUAL = 2'b00;
    localparam logic [1:0] ST_AUTO   = 2'b01;
    localparam logic [1:0] ST_PAUSE  = 2'b10;

    // Width of a counter that must hold the values 0..value-1.
    // A value of 1 (or less) still gets a one-bit counter.
    function automatic int clog2_w(input int value);
        int width;
        width = 1;
        while ((64'd1 << width) < 64'(value)) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage : sel_scanner_pkg

// File: rtl/sel_scanner_if.sv
// ---------------------------------------------------------------------------
// sel_scanner_if
// Bundles the board-facing signals of the select scanner.
//
// Parameter:
//   SEL_W     width of the select bus; must match the scanner's SEL_W.
//
// Signals:
//   mode      switch level, 0 = manual stepping, 1 = auto scan
//   hold      switch level, 1 = pause auto scan
//   step_btn  raw push button, active-high, asynchronous to clk
//   dir       (only with SEL_SCANNER_DIR_EN) 0 = count up, 1 = count down
//   sel       registered select for the downstream mux
//   wrap      one-cycle pulse when sel wraps around
//   state     FSM state for the LEDs (see sel_scanner_pkg)
//
// Modports:
//   master    the side that drives the switches/button and reads the select
//   slave     the scanner itself
//
// Optional feature macro: SEL_SCANNER_DIR_EN adds the dir signal.
// ---------------------------------------------------------------------------
interface sel_scanner_if #(
    parameter int SEL_W = 3
);

    logic             mode;
    logic             hold;
    logic             step_btn;
`ifdef SEL_SCANNER_DIR_EN
    logic             dir;
`endif
    logic [SEL_W-1:0] sel;
    logic             wrap;
    logic [1:0]       state;

`ifdef SEL_SCANNER_DIR_EN
    modport master (
        output mode, hold, step_btn, dir,
        input  sel, wrap, state
    );

    modport slave (
        input  mode, hold, step_btn, dir,
        output sel, wrap, state
    );
`else
    modport master (
        output mode, hold, step_btn,
        input  sel, wrap, state
    );

    modport slave (
        input  mode, hold, step_btn,
        output sel, wrap, state
    );
`endif

endinterface : sel_scanner_if

// File: rtl/sel_scanner_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// Synchronizes a raw push button, debounces it and produces a one-cycle
// pulse for every accepted press. Intended to be reused for any board button.
//
// Parameter:
//   DEBOUNCE_CYCLES  consecutive equal synchronized samples needed before a
//                    new button level is accepted (>= 1)
//
// Ports:
//   clk    clock, all state on the rising edge
//   rst_n  asynchronous active-low reset
//   btn    raw button level, active-high, asynchronous to clk
//   pulse  registered one-cycle pulse on an accepted 0->1 transition
// ---------------------------------------------------------------------------
module btn_debounce
    import sel_scanner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);

    // Arming needs the debounce window plus the synchronizer depth so the
    // reset zeros still sitting in the synchronizer can never count as a
    // genuine release.
    localparam int ARM_CYCLES = DEBOUNCE_CYCLES + 2;
    localparam int CNT_W      = clog2_w(DEBOUNCE_CYCLES);
    localparam int ARM_W      = clog2_w(ARM_CYCLES);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_CYCLES - 1);

    logic             btn_meta;
    logic             btn_s;
    logic             level;
    logic [CNT_W-1:0] cnt;
    logic             armed;
    logic [ARM_W-1:0] arm_cnt;

    // Two-flop synchronizer for the raw button.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta <= 1'b0;
            btn_s    <= 1'b0;
        end else begin
            btn_meta <= btn;
            btn_s    <= btn_meta;
        end
    end

    // The counter tracks how long the synchronized sample has differed from
    // the accepted level; any agreeing sample restarts the count.
    //
    // After reset the button may already be held down, so a press is only
    // reported once the debouncer has been armed by a real release: either
    // an accepted 1->0 transition or a long enough run of low samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level   <= 1'b0;
            cnt     <= '0;
            pulse   <= 1'b0;
            armed   <= 1'b0;
            arm_cnt <= '0;
        end else begin
            pulse <= 1'b0;

            if (btn_s != level) begin
                if (cnt == CNT_LAST) begin
                    level <= btn_s;
                    cnt   <= '0;
                    pulse <= btn_s & armed;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end

            if (!armed) begin
                if (btn_s) begin
                    arm_cnt <= '0;
                end else if ((arm_cnt == ARM_LAST) || level) begin
                    armed   <= 1'b1;
                    arm_cnt <= '0;
                end else begin
                    arm_cnt <= arm_cnt + 1'b1;
                end
            end
        end
    end

endmodule : btn_debounce

// File: rtl/sel_scanner.sv
// ---------------------------------------------------------------------------
// sel_scanner
// Drives the select lines of a CHANNELS-way mux. In manual mode each
// debounced button press steps to the next channel; in auto mode the select
// advances every DWELL_CYCLES clocks and can be paused with the hold switch.
//
// Parameters:
//   CHANNELS         number of channels scanned (2..256)
//   SEL_W            select width, 2**SEL_W >= CHANNELS
//   DWELL_CYCLES     clocks spent on each channel in auto mode (>= 2)
//   DEBOUNCE_CYCLES  stable samples needed to accept a button level (>= 1)
//
// Ports:
//   clk    clock, all state on the rising edge
//   rst_n  asynchronous active-low reset
//   bus    sel_scanner_if.slave: mode, hold, step_btn (and dir) in;
//          sel, wrap, state out, all registered
//
// Optional feature macro: SEL_SCANNER_DIR_EN adds a synchronized dir input
// (0 = up, 1 = down). Without it the select only counts up.
// ---------------------------------------------------------------------------
module sel_scanner
    import sel_scanner_pkg::*;
#(
    parameter int CHANNELS        = 8,
    parameter int SEL_W           = 3,
    parameter int DWELL_CYCLES    = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic         clk,
    input  logic         rst_n,
    sel_scanner_if.slave bus
);

    localparam int DWELL_W = clog2_w(DWELL_CYCLES);

    localparam logic [SEL_W-1:0]   LAST_SEL   = SEL_W'(CHANNELS - 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);

    logic               mode_meta;
    logic               mode_s;
    logic               hold_meta;
    logic               hold_s;
`ifdef SEL_SCANNER_DIR_EN
    logic               dir_meta;
    logic               dir_s;
`endif

    logic               step_pulse;

    logic [1:0]         state_q;
    logic [1:0]         state_d;
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] dwell_d;
    logic               dwell_done;

    logic               advance;
    logic               wrap_cond;
    logic [SEL_W-1:0]   sel_next;
    logic [SEL_W-1:0]   sel_q;
    logic               wrap_q;

    // Two-flop synchronizers for the switch levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_meta <= 1'b0;
            mode_s    <= 1'b0;
            hold_meta <= 1'b0;
            hold_s    <= 1'b0;
`ifdef SEL_SCANNER_DIR_EN
            dir_meta  <= 1'b0;
            dir_s     <= 1'b0;
`endif
        end else begin
            mode_meta <= bus.mode;
            mode_s    <= mode_meta;
            hold_meta <= bus.hold;
            hold_s    <= hold_meta;
`ifdef SEL_SCANNER_DIR_EN
            dir_meta  <= bus.dir;
            dir_s     <= dir_meta;
`endif
        end
    end

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_step_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (bus.step_btn),
        .pulse (step_pulse)
    );

    // A step press and the dwell terminal count are OR-ed into a single
    // advance, so a coincidence of the two still moves sel by one.
    always_comb begin
        dwell_done = (dwell_q == DWELL_LAST);
        advance    = step_pulse || ((state_q == ST_AUTO) && dwell_done);
        wrap_cond  = (sel_q == LAST_SEL);
        sel_next   = wrap_cond ? '0 : sel_q + 1'b1;
`ifdef SEL_SCANNER_DIR_EN
        if (dir_s) begin
            wrap_cond = (sel_q == '0);
            sel_next  = wrap_cond ? LAST_SEL : sel_q - 1'b1;
        end
`endif
    end

    // Mode/hold FSM and dwell counter. The counter only runs in AUTO, is
    // frozen in PAUSE so a resume picks up the remaining dwell, and is held
    // at zero in MANUAL so every MANUAL->AUTO entry starts a fresh dwell.
    // mode=0 wins over hold.
    always_comb begin
        state_d = state_q;
        dwell_d = dwell_q;

        case (state_q)
            ST_MANUAL: begin
                dwell_d = '0;
                if (mode_s) begin
                    state_d = ST_AUTO;
                end
            end

            ST_AUTO: begin
                if (step_pulse || dwell_done) begin
                    dwell_d = '0;
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
                if (!mode_s) begin
                    state_d = ST_MANUAL;
                    dwell_d = '0;
                end else if (hold_s) begin
                    state_d = ST_PAUSE;
                end
            end

            ST_PAUSE: begin
                if (!mode_s) begin
                    state_d = ST_MANUAL;
                    dwell_d = '0;
                end else if (!hold_s) begin
                    state_d = ST_AUTO;
                end
            end

            default: begin
                state_d = ST_MANUAL;
                dwell_d = '0;
            end
        endcase
    end

    // State, dwell count, select and wrap flag. wrap is raised in the same
    // cycle the wrapped select value first appears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_MANUAL;
            dwell_q <= '0;
            sel_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            wrap_q  <= advance && wrap_cond;
            if (advance) begin
                sel_q <= sel_next;
            end
        end
    end

    assign bus.sel   = sel_q;
    assign bus.wrap  = wrap_q;
    assign bus.state = state_q;

endmodule : sel_scanner
